// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the cordic request scheduler.
// The core finishes 16 iterations at 2 per enabled cycle.
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_RESP
    } state_t;

    localparam int CORE_ITERS           = 16;
    localparam int ITERS_PER_CYCLE      = 2;
    localparam int EXPECTED_DONE_CYCLES = CORE_ITERS / ITERS_PER_CYCLE;

    localparam logic [31:0] FP_ZERO = 32'h0;

endpackage

// File: rtl/cordic_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after
// the pointer, wrapping, wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_j;

    always_comb begin
        w_j   = '0;
        o_idx = '0;
        o_any = |i_valid;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_valid[w_j]) begin
                o_idx = w_j;
            end
        end
        o_grant = o_any ? (NUM_REQ'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one cordic cosine core between NUM_REQ requesters, round robin,
// returning each result tagged with its requester id.
module cordic_req_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 32
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  core_clk_en,
    output logic                  core_start,
    output logic [31:0]           core_dataa,
    input  logic [31:0]           core_result,
    input  logic                  core_done
);

    // A timeout shorter than the core's own latency would never succeed.
    localparam int TMO   = (TIMEOUT > EXPECTED_DONE_CYCLES) ?
                           TIMEOUT : EXPECTED_DONE_CYCLES + 1;
    localparam int CNT_W = $clog2(TMO);

    state_t           r_state;
    state_t           w_next;
    logic [ID_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_id;
    logic [31:0]      r_op;
    logic [31:0]      r_res;
    logic             r_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [31:0]        w_op;
    logic               w_tmo;
    logic [ID_W-1:0]    w_ptr_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_op = req_data[i*32 +: 32];
            end
        end
    end

    assign w_tmo     = (r_cnt == CNT_W'(TMO - 1));
    assign w_ptr_nxt = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_BUSY;
            S_BUSY:   if (core_done || w_tmo) w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id <= w_idx;
                        r_op <= w_op;
                    end
                end
                S_LAUNCH: r_cnt <= '0;
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done in the final timeout cycle still wins.
                    if (core_done) begin
                        r_res <= core_result;
                        r_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_res <= FP_ZERO;
                        r_err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) r_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready   = (r_state == S_IDLE && !aclr) ? w_grant : '0;
        rsp_valid   = (r_state == S_RESP);
        busy        = (r_state != S_IDLE);
        core_start  = (r_state == S_LAUNCH);
        core_clk_en = (r_state == S_LAUNCH) ||
                      (r_state == S_BUSY && !core_done);
        core_dataa  = r_op;
        rsp_id      = r_id;
        rsp_data    = r_res;
        rsp_err     = r_err;
    end

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Self-checking bench for cordic_req_scheduler with a behavioural core stub
// and a queue-free round-robin reference model.
module tb_cordic_req_scheduler;

    localparam int NR  = 4;
    localparam int IDW = 2;

    logic            clock = 1'b0;
    logic            aclr;
    logic [NR-1:0]   req_valid;
    logic [NR*32-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            core_clk_en;
    logic            core_start;
    logic [31:0]     core_dataa;
    logic [31:0]     core_result;
    logic            core_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_ptr    = 0;
    int done_iters = 16;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    cordic_req_scheduler #(
        .NUM_REQ (NR),
        .ID_W    (IDW),
        .TIMEOUT (32)
    ) dut (
        .clock       (clock),
        .aclr        (aclr),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .core_clk_en (core_clk_en),
        .core_start  (core_start),
        .core_dataa  (core_dataa),
        .core_result (core_result),
        .core_done   (core_done)
    );

    // Core stub: cos(0.5) for 0.5, a fixed scramble otherwise.
    function automatic logic [31:0] core_fn(input logic [31:0] x);
        if (x == 32'h3F00_0000) return 32'h3F60_A8B6;
        return {x[15:0], x[31:16]} ^ 32'hC0DE_0000;
    endfunction

    logic [31:0] s_op;
    int          s_iter;
    logic        s_run;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            s_op   <= '0;
            s_iter <= 0;
            s_run  <= 1'b0;
        end else if (core_clk_en) begin
            if (core_start) begin
                s_op   <= core_dataa;
                s_iter <= 0;
                s_run  <= 1'b1;
            end else if (s_run) begin
                s_iter <= s_iter + 2;
            end
        end
    end

    assign core_done   = s_run && (s_iter >= done_iters);
    assign core_result = core_done ? core_fn(s_op) : 32'hDEAD_BEEF;

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic txn(input logic [NR-1:0] vmask, input int lat,
                       input logic err, input int bp, input bit hold,
                       input string tag, output int acc);
        int g;
        int n;
        logic [31:0] op;
        logic [31:0] exp_d;
        g = pick(vmask, m_ptr);
        op = req_data[g*32 +: 32];
        exp_d = err ? 32'h0 : core_fn(op);
        rsp_ready = (bp == 0);
        req_valid = vmask;
        #1;
        acc = cyc;
        chk({tag, " ready"}, 32'(req_ready), 32'(4'b0001 << g));
        tick();
        if (!hold) req_valid = '0;
        chk({tag, " start"}, 32'(core_start), 32'd1);
        chk({tag, " dataa"}, core_dataa, op);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " id"}, 32'(rsp_id), 32'(g));
        chk({tag, " data"}, rsp_data, exp_d);
        chk({tag, " err"}, 32'(rsp_err), 32'(err));
        if (bp > 0) req_valid = vmask;
        for (int b = 0; b < bp; b++) begin
            chk({tag, " bp clk_en"}, 32'(core_clk_en), 32'd0);
            tick();
            chk({tag, " bp valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " bp data"}, rsp_data, exp_d);
            chk({tag, " bp ready"}, 32'(req_ready), 32'd0);
        end
        if (bp > 0) begin
            req_valid = '0;
            rsp_ready = 1'b1;
        end
        tick();
        chk({tag, " done"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
        m_ptr = (g + 1) % NR;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int hits;
        logic [NR-1:0] vm;

        aclr      = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        rsp_ready = 1'b0;
        #3;
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst clk_en", 32'(core_clk_en), 32'd0);
        chk("rst start", 32'(core_start), 32'd0);
        chk("rst dataa", core_dataa, 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        tick();
        tick();
        req_valid = '0;
        aclr = 1'b0;
        tick();
        chk("post rst busy", 32'(busy), 32'd0);

        for (int i = 0; i < NR; i++) req_data[i*32 +: 32] = $urandom;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            txn(4'hF, 11, 1'b0, 0, 1'b1, "rr", acc);
            chk("rr order", 32'(m_ptr), 32'((k + 1) % NR));
            if (k > 0) chk("rr spacing", 32'(acc - prev), 32'd12);
            prev = acc;
        end
        req_valid = '0;
        tick();

        req_data[2*32 +: 32] = 32'h3F00_0000;
        txn(4'b0100, 11, 1'b0, 0, 1'b0, "single", acc);

        req_data[1*32 +: 32] = $urandom;
        txn(4'b1111, 11, 1'b0, 20, 1'b0, "bp", acc);

        done_iters = 1000;
        req_data[0*32 +: 32] = $urandom;
        txn(4'b0001, 34, 1'b1, 0, 1'b0, "timeout", acc);
        done_iters = 16;
        req_data[3*32 +: 32] = $urandom;
        txn(4'b1000, 11, 1'b0, 0, 1'b0, "after tmo", acc);

        done_iters = 62;
        req_data[1*32 +: 32] = $urandom;
        txn(4'b0010, 34, 1'b0, 0, 1'b0, "collide", acc);
        done_iters = 16;

        req_data[3*32 +: 32] = $urandom;
        req_valid = 4'b1000;
        #1;
        chk("midrst ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst busy before", 32'(busy), 32'd1);
        #2;
        aclr = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst clk_en", 32'(core_clk_en), 32'd0);
        chk("midrst start", 32'(core_start), 32'd0);
        chk("midrst dataa", core_dataa, 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst rsp_id", 32'(rsp_id), 32'd0);
        chk("midrst rsp_data", rsp_data, 32'd0);
        chk("midrst rsp_err", 32'(rsp_err), 32'd0);
        m_ptr = 0;
        tick();
        aclr = 1'b0;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b0) hits++;
        end
        chk("midrst no rsp", 32'(hits), 32'd0);
        for (int i = 0; i < NR; i++) req_data[i*32 +: 32] = $urandom;
        txn(4'hF, 11, 1'b0, 0, 1'b0, "midrst next", acc);

        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < NR; i++) req_data[i*32 +: 32] = $urandom;
            vm = 4'($urandom_range(1, 15));
            txn(vm, 11, 1'b0, $urandom_range(0, 3), 1'b0, "rand", acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_req_scheduler.md
Name: cordic_req_scheduler

Overview:
Round-robin scheduler that shares one cordic cosine core between NUM_REQ requesters. Each requester posts a 32-bit float operand with a valid/ready handshake. The block sequences the core with start and clk_en, detects done, freezes the core, and returns the float result tagged with the requester id. It sits between the custom-instruction or bus front ends and the single cordic instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester id
TIMEOUT, 32, maximum BUSY cycles to wait for core_done before an error response (must be >8)

Ports:
clock  in  1  single clock, rising edge
aclr  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operand valid
req_data  in  NUM_REQ*32  flattened operands; requester i uses bits [i*32+31:i*32]
req_ready  out  NUM_REQ  one-hot accept strobe
rsp_valid  out  1  result available
rsp_ready  in  1  result consumer ready
rsp_id  out  ID_W  requester the result belongs to
rsp_data  out  32  float result; 0 when rsp_err=1
rsp_err  out  1  core timeout
busy  out  1  high whenever state is not IDLE
core_clk_en  out  1  to cordic clk_en
core_start  out  1  to cordic start
core_dataa  out  32  to cordic dataa
core_result  in  32  from cordic result
core_done  in  1  from cordic done

Behaviour:
- Reset (aclr high, asynchronous): state=IDLE, rr_ptr=0, timeout counter=0, all latched id/data/result registers=0. Every output is 0 during and after reset. A reset asserted mid-operation abandons the transaction with no response; the core is restarted on the next launch.
- States: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - grant = the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping.
  - req_ready[grant]=1 combinationally, all other bits 0; req_ready=0 when no valid.
  - Handshake completes on req_valid&req_ready. The operand and id are latched on that edge. Next state is LAUNCH.
  - Requesters hold valid and data stable until ready; req_valid dropped before ready is allowed.
- LAUNCH, 1 cycle: core_start=1, core_clk_en=1, core_dataa=latched operand. Next state is BUSY, with counter cleared.
- BUSY:
  - core_clk_en = !core_done, combinational, so the core freezes on the first done cycle.
  - core_start=0. core_dataa holds the operand.
  - When core_done=1, latch core_result, set err=0, go to RESP.
  - When counter==TIMEOUT-1 without done, set err=1, data=0, go to RESP.
  - Done takes priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid=1 with rsp_id, rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rr_ptr = (id+1) mod NUM_REQ, then go to IDLE. No new request is accepted in the same cycle.
  - rsp_ready may be high before rsp_valid; completion still takes exactly one RESP cycle.
- Latency: acceptance at cycle 0, LAUNCH at 1, core_done at cycle 10 (the core advances 2 iterations per cycle and done=index 16), rsp_valid from cycle 11. Throughput is one operation per 12 cycles when rsp_ready is tied high.
- core_clk_en=0 and core_start=0 in IDLE and RESP.
- Outputs are driven by state and registered data only; no output depends combinationally on rsp_ready.

Decomposition:
- Package cordic_sched_pkg:
  - state enum
  - CORE_ITERS=16
  - ITERS_PER_CYCLE=2
  - EXPECTED_DONE_CYCLES=8
  - FP_ZERO=32'h0
- Sub-module rr_arbiter: purely combinational. Takes req_valid and rr_ptr; produces the one-hot grant, grant index and any_valid.
- The FSM, counter and latches live in the top level.

Test Plan:
- Single request: requester 2 sends 32'h3F000000 (0.5) with rsp_ready=1. Required: req_ready=4'b0100 at cycle 0, core_start at cycle 1, rsp_valid at cycle 11, rsp_id=2, rsp_err=0, rsp_data within 2^-17 of 0x3F60A8B6 (cos 0.5).
- Round robin: all four requesters valid continuously. Required: grant order 0,1,2,3,0. Each response is tagged correctly and starts 12 cycles after the previous one.
- Back-pressure: hold rsp_ready=0 for 20 cycles. Required: rsp_valid and rsp_data stable, core_clk_en=0, req_ready=0 throughout. The response completes in the cycle rsp_ready rises.
- Timeout: stub core_done=0. Required: rsp_valid rises TIMEOUT+2=34 cycles after acceptance, with rsp_err=1, rsp_data=0. The arbiter then accepts the next request.
- Reset mid-operation: assert aclr asynchronously in BUSY cycle 5. Required: all outputs 0 immediately, no response is issued, and the next request is served with rr_ptr=0 priority.
- Done/timeout collision: with TIMEOUT=9, core_done rises at BUSY cycle 8. Required: rsp_err=0 and the real result is returned.
